button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable synchronized samples required to accept a level change; legal range 1..2^20.
REQ-002 Parameter ACTIVE_LOW, default 1: 1 means a raw_button value of 0 is "pressed" (board pushbuttons).
REQ-003 Parameter REPEAT_CYCLES, default 25000000: autorepeat period in cycles; used only under the autorepeat macro; legal range 1..2^26.
REQ-004 clk  input  1  single system clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 raw_button  input  1  asynchronous, bouncing pushbutton pin.
REQ-007 level  output  1  debounced pressed state, active-high.
REQ-008 press_pulse  output  1  one-cycle strobe on an accepted press; this is the in_signal source of the downstream one-cycle start stretcher.
REQ-009 release_pulse  output  1  one-cycle strobe on an accepted release.

Function
REQ-010 raw_button shall pass through a 2-flop synchronizer; the synchronized output is then normalized to active-high per ACTIVE_LOW.
REQ-011 The FSM shall have states IDLE, WAIT_PRESS, PRESSED and WAIT_RELEASE, with a single shared counter.
REQ-012 IDLE: on a synchronized pressed sample, go to WAIT_PRESS with counter=1.
REQ-013 WAIT_PRESS: on a pressed sample, increment the counter; when the counter reaches DEBOUNCE_CYCLES, go to PRESSED, set level=1 and pulse press_pulse; on a released sample, return to IDLE with counter=0 and no pulse.
REQ-014 PRESSED: on a released sample, go to WAIT_RELEASE with counter=1.
REQ-015 WAIT_RELEASE: on a released sample, increment the counter; when it reaches DEBOUNCE_CYCLES, go to IDLE, set level=0 and pulse release_pulse; on a pressed sample, return to PRESSED with no pulse.
REQ-016 Latency: if edge N is the first edge that captures a stable pressed raw_button, press_pulse and level shall rise at edge N+1+DEBOUNCE_CYCLES; release timing is symmetric.
REQ-017 With DEBOUNCE_CYCLES=1, a single synchronized sample shall be accepted, and the FSM still passes through WAIT_PRESS/WAIT_RELEASE.
REQ-018 press_pulse and release_pulse shall be registered, high for exactly one cycle, and never high in the same cycle.
REQ-019 Any bounce shorter than DEBOUNCE_CYCLES samples shall produce no pulse and no change on level.
REQ-020 Counter width shall be clog2(max(DEBOUNCE_CYCLES,REPEAT_CYCLES)+1); the counter shall saturate at its terminal value and never wrap.
REQ-021 All outputs shall be driven from flops; there are no combinational paths from raw_button to any output.

Reset
REQ-022 When reset=1 at a posedge, state=IDLE, counter=0, level=0, press_pulse=0 and release_pulse=0.
REQ-023 Reset shall load both synchronizer flops with the released level (1 if ACTIVE_LOW=1, otherwise 0).
REQ-024 Reset in any state shall abort the operation; a button still held after reset must complete a full debounce, after which it yields exactly one press_pulse.
REQ-025 A pulse scheduled on the same edge as reset shall be suppressed; reset has priority.

Configuration
REQ-026 Macro BUTTON_DEBOUNCER_AUTOREPEAT_EN defined: while in PRESSED, the counter counts cycles and press_pulse re-asserts for one cycle every REPEAT_CYCLES cycles after the initial accepted press; the count restarts on each repeat; a released sample stops repeating immediately.
REQ-027 Macro not defined: exactly one press_pulse per accepted press, the REPEAT_CYCLES parameter is ignored, and no repeat logic is synthesized.

Structure
REQ-028 Package button_debouncer_pkg shall hold the FSM state typedef (2-bit encoding), DEFAULT_DEBOUNCE_CYCLES=50000 and DEFAULT_REPEAT_CYCLES=25000000.
REQ-029 The synchronizer shall be a separate sub-module, sync_2ff (1-bit, reset value as a parameter), reusable for other board inputs.

Verification (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, REPEAT_CYCLES=10 unless stated)
REQ-030 Clean press: raw_button 1->0 held for 20 cycles -> one press_pulse at edge N+5, level=1 from edge N+5; release after 20 cycles -> one release_pulse 5 edges later.
REQ-031 Bounce: raw_button toggles low/high every 2 cycles for 12 cycles, then stays low -> no pulse during toggling; exactly one press_pulse 5 edges after the last transition.
REQ-032 Reset mid-debounce: reset pulsed in WAIT_PRESS with counter=3 -> no press_pulse; with the button held, press_pulse at 5 edges after reset deasserts.
REQ-033 Edge case DEBOUNCE_CYCLES=1: a 1-cycle-wide low glitch aligned to an edge -> press_pulse, then release_pulse, never in the same cycle.
REQ-034 Autorepeat (macro defined): button held 40 cycles after acceptance -> press_pulses at acceptance+0, +10, +20, +30, +40; the macro undefined on the same stimulus -> a single press_pulse.
REQ-035 Downstream check: press_pulse driving the one-cycle start stretcher -> exactly one start strobe per accepted press.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// Shared types and defaults for the pushbutton debouncer.
// Optional autorepeat: define BUTTON_DEBOUNCER_AUTOREPEAT_EN.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned DEFAULT_REPEAT_CYCLES   = 25000000;

  function automatic int unsigned max_u(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button pin in, debounced level and press/release strobes out.
// master = debouncer side, slave = consumer side.
interface button_debouncer_if;
  logic raw_button;
  logic level;
  logic press_pulse;
  logic release_pulse;

  modport master (
    input  raw_button,
    output level,
    output press_pulse,
    output release_pulse
  );

  modport slave (
    output raw_button,
    input  level,
    input  press_pulse,
    input  release_pulse
  );
endinterface

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchronizer for one asynchronous board input.
// RST_VAL is the level both flops take on reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Pushbutton debouncer: 2FF sync, 4-state FSM, registered strobes.
// Define BUTTON_DEBOUNCER_AUTOREPEAT_EN for press autorepeat.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input logic              clk,
  input logic              reset,
  button_debouncer_if.master btn
);

  localparam int unsigned CNT_MAX =
    max_u(DEBOUNCE_CYCLES, REPEAT_CYCLES);
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEB = cnt_t'(DEBOUNCE_CYCLES);
  localparam cnt_t ONE = cnt_t'(1);
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
  localparam cnt_t REP = cnt_t'(REPEAT_CYCLES);
`endif

  logic   sync_q;
  logic   pressed;
  state_t state, state_n;
  cnt_t   cnt, cnt_n, cnt_inc;
  logic   level_q, level_n;
  logic   pp_q, pp_n;
  logic   rp_q, rp_n;

  sync_2ff #(
    .RST_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn.raw_button),
    .q     (sync_q)
  );

  assign pressed = sync_q ^ ACTIVE_LOW;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      level_q <= 1'b0;
      pp_q    <= 1'b0;
      rp_q    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      level_q <= level_n;
      pp_q    <= pp_n;
      rp_q    <= rp_n;
    end
  end

  // A count already at DEB accepts regardless of the sample,
  // so DEBOUNCE_CYCLES=1 takes one sample yet visits WAIT_*.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = level_q;
    pp_n    = 1'b0;
    rp_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pressed) begin
          state_n = WAIT_PRESS;
          cnt_n   = ONE;
        end else begin
          cnt_n   = '0;
        end
      end
      WAIT_PRESS: begin
        if (cnt >= DEB || (pressed && cnt_inc >= DEB)) begin
          state_n = PRESSED;
          cnt_n   = '0;
          level_n = 1'b1;
          pp_n    = 1'b1;
        end else if (pressed) begin
          cnt_n   = cnt_inc;
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_n = WAIT_RELEASE;
          cnt_n   = ONE;
        end else begin
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
          if (cnt_inc >= REP) begin
            pp_n  = 1'b1;
            cnt_n = '0;
          end else begin
            cnt_n = cnt_inc;
          end
`else
          cnt_n = '0;
`endif
        end
      end
      WAIT_RELEASE: begin
        if (cnt >= DEB || (!pressed && cnt_inc >= DEB)) begin
          state_n = IDLE;
          cnt_n   = '0;
          level_n = 1'b0;
          rp_n    = 1'b1;
        end else if (!pressed) begin
          cnt_n   = cnt_inc;
        end else begin
          state_n = PRESSED;
          cnt_n   = '0;
        end
      end
    endcase
  end

  assign btn.level         = level_q;
  assign btn.press_pulse   = pp_q;
  assign btn.release_pulse = rp_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench: D=1 vector table, hand corner sequences and a random
// run against a run-length reference model (D=4, R=10).
module tb_button_debouncer;

  localparam int D = 4;
  localparam int R = 10;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;

  always #5 clk = ~clk;

  button_debouncer_if bi ();
  button_debouncer_if bj ();

  button_debouncer #(
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (1'b1),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk   (clk),
    .reset (rst0),
    .btn   (bi)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES (1),
    .ACTIVE_LOW      (1'b1),
    .REPEAT_CYCLES   (R)
  ) dut1 (
    .clk   (clk),
    .reset (rst1),
    .btn   (bj)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // downstream start stretcher fed by press_pulse
  logic pp_d = 1'b0;
  int   start_cnt = 0;
  always @(posedge clk) begin
    pp_d <= bi.press_pulse;
    if (bi.press_pulse && !pp_d) start_cnt <= start_cnt + 1;
  end

  // reference model: run length of samples disagreeing with level
  logic m_s1, m_s2, m_level, m_pp, m_rp, m_prevp;
  int   m_run, m_rep, m_press_cnt = 0;

  task automatic model_edge(input logic r, input logic rs);
    logic smp, p;
    if (rs) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_level = 1'b0; m_pp = 1'b0; m_rp = 1'b0;
      m_prevp = 1'b0; m_run = 0; m_rep = 0;
      return;
    end
    smp = m_s2; m_s2 = m_s1; m_s1 = r;
    p = ~smp;
    m_pp = 1'b0; m_rp = 1'b0;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    if (m_level) begin
      if (!p || !m_prevp) m_rep = 0;
      else begin
        m_rep++;
        if (m_rep == R) begin m_pp = 1'b1; m_rep = 0; end
      end
    end
`endif
    if (p != m_level) begin
      m_run++;
      if (m_run == D) begin
        m_level = p; m_run = 0;
        if (p) begin m_pp = 1'b1; m_rep = 0; end
        else m_rp = 1'b1;
      end
    end else begin
      m_run = 0;
    end
    m_prevp = p;
    if (m_pp) m_press_cnt++;
  endtask

  task automatic step(input logic r, input logic rs);
    bi.raw_button = r;
    rst0 = rs;
    @(posedge clk);
    #1;
    model_edge(r, rs);
    chk("model",
        {bi.level, bi.press_pulse, bi.release_pulse},
        {m_level, m_pp, m_rp});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  typedef struct packed {
    logic rst;
    logic raw;
    logic lvl;
    logic pp;
    logic rp;
  } vec_t;

  vec_t tbl [19];

  initial begin
    int npp;
    int seg_v, seg_n;

    tbl = '{5'b11000, 5'b01000, 5'b00000, 5'b01000, 5'b01000,
            5'b01110, 5'b01100, 5'b01001, 5'b01000, 5'b00000,
            5'b00000, 5'b00000, 5'b00110, 5'b00100, 5'b01100,
            5'b01100, 5'b01100, 5'b01001, 5'b01000};

    rst0 = 1'b1;
    bi.raw_button = 1'b1;
    rst1 = 1'b1;
    bj.raw_button = 1'b1;

    // DEBOUNCE_CYCLES=1: one-cycle glitch, then a held press
    for (int i = 0; i < 19; i++) begin
      rst1 = tbl[i].rst;
      bj.raw_button = tbl[i].raw;
      @(posedge clk);
      #1;
      chk($sformatf("d1_row%0d", i),
          {bj.level, bj.press_pulse, bj.release_pulse},
          {tbl[i].lvl, tbl[i].pp, tbl[i].rp});
      chk("d1_excl",
          int'(bj.press_pulse && bj.release_pulse), 0);
    end

    step(1'b1, 1'b1);
    chk("reset_state",
        {bi.level, bi.press_pulse, bi.release_pulse}, 0);
    idle(8);

    // clean press and release
    npp = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0);
      npp += int'(bi.press_pulse);
      if (k == 6) chk("clean_press_at", int'(bi.press_pulse), 1);
      if (k == 5) chk("clean_lvl_before", int'(bi.level), 0);
      if (k == 6) chk("clean_lvl_at", int'(bi.level), 1);
    end
    chk("clean_press_cnt", npp, 1);
    npp = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b0);
      npp += int'(bi.release_pulse);
      if (k == 6) chk("clean_rel_at", int'(bi.release_pulse), 1);
      if (k == 6) chk("clean_rel_lvl", int'(bi.level), 0);
    end
    chk("clean_rel_cnt", npp, 1);

    // bounce: 2-cycle toggles, then held low
    npp = 0;
    for (int k = 1; k <= 24; k++) begin
      step((k <= 12) ? logic'(((k - 1) / 2) % 2) : 1'b0, 1'b0);
      if (k < 18) npp += int'(bi.press_pulse);
      if (k == 18) chk("bounce_press_at", int'(bi.press_pulse), 1);
    end
    chk("bounce_no_early", npp, 0);
    idle(10);

    // reset in WAIT_PRESS with count 3, button still held
    for (int k = 1; k <= 5; k++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("rst_suppress", int'(bi.press_pulse), 0);
    npp = 0;
    for (int j = 1; j <= 10; j++) begin
      step(1'b0, 1'b0);
      npp += int'(bi.press_pulse);
      if (j == 6) chk("rst_press_at", int'(bi.press_pulse), 1);
    end
    chk("rst_press_cnt", npp, 1);
    idle(10);

    // long hold: repeats only with autorepeat
    npp = 0;
    for (int k = 1; k <= 50; k++) begin
      step(1'b0, 1'b0);
      npp += int'(bi.press_pulse);
    end
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    chk("hold_press_cnt", npp, 5);
`else
    chk("hold_press_cnt", npp, 1);
`endif
    idle(10);

    // random bouncing with occasional reset
    for (int s = 0; s < 400; s++) begin
      seg_v = $urandom_range(0, 1);
      seg_n = ($urandom_range(0, 3) == 0) ?
              $urandom_range(4, 25) : $urandom_range(1, 5);
      for (int i = 0; i < seg_n; i++)
        step(logic'(seg_v), ($urandom_range(0, 299) == 0));
    end

    idle(12);
    chk("start_strobes", start_cnt, m_press_cnt);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
